// File: rtl/stream_xbar_arbiter.sv
// Per-master round-robin arbiter for the stream crossbar: grants one slave per master port and
// holds the grant until the packet ends, re-arbitrating in the same cycle so there is no bubble.
module stream_xbar_arbiter #(
   parameter  int S_DATA_COUNT = 2,
   parameter  int M_DATA_COUNT = 3,
   parameter  int LOCK_ON_LAST = 1,
   localparam int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1,
   localparam int S_ID_WIDTH   = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [S_DATA_COUNT-1:0] s_valid_i,
   input  logic [T_DEST_WIDTH-1:0] s_dest_i [S_DATA_COUNT],
   input  logic [S_DATA_COUNT-1:0] s_last_i,
   input  logic [M_DATA_COUNT-1:0] m_ready_i,
   output logic [M_DATA_COUNT-1:0] m_active_o,
   output logic [S_ID_WIDTH-1:0]   m_sel_o [M_DATA_COUNT],
   output logic [S_DATA_COUNT-1:0] s_grant_o,
   output logic [M_DATA_COUNT-1:0] conflict_o,
   output logic [S_DATA_COUNT-1:0] s_dest_err_o
);

   typedef enum logic {StIdle, StLocked} state_e;

   state_e                  r_state    [M_DATA_COUNT];
   logic [S_ID_WIDTH-1:0]   r_owner    [M_DATA_COUNT];
   logic [S_ID_WIDTH-1:0]   r_ptr      [M_DATA_COUNT];
   logic [M_DATA_COUNT-1:0] r_conflict;
   logic [S_DATA_COUNT-1:0] r_dest_err;

   logic [S_DATA_COUNT-1:0] w_owned    [M_DATA_COUNT];
   logic [S_DATA_COUNT-1:0] w_req_raw  [M_DATA_COUNT];
   logic [S_DATA_COUNT-1:0] w_req      [M_DATA_COUNT];
   logic [S_ID_WIDTH-1:0]   w_start    [M_DATA_COUNT];
   logic [S_ID_WIDTH-1:0]   w_pick     [M_DATA_COUNT];
   logic [M_DATA_COUNT-1:0] w_any;
   logic [M_DATA_COUNT-1:0] w_end;
   logic [M_DATA_COUNT-1:0] w_conflict;
   logic [S_DATA_COUNT-1:0] w_dest_err;
   logic [S_DATA_COUNT-1:0] w_grant;

   function automatic logic [S_ID_WIDTH-1:0] wrap_inc(input logic [S_ID_WIDTH-1:0] x);
      return (int'(x) == S_DATA_COUNT - 1) ? '0 : x + 1'b1;
   endfunction

   // Returns {found, index} of the first request scanning upward from start, wrapping.
   function automatic logic [S_ID_WIDTH:0] rr_pick(input logic [S_DATA_COUNT-1:0] req,
                                                   input logic [S_ID_WIDTH-1:0]   start);
      logic [S_ID_WIDTH:0] res;
      int                  idx;
      res = '0;
      for (int off = S_DATA_COUNT - 1; off >= 0; off--) begin
         idx = int'(start) + off;
         if (idx >= S_DATA_COUNT) idx = idx - S_DATA_COUNT;
         if (req[idx]) res = {1'b1, idx[S_ID_WIDTH-1:0]};
      end
      return res;
   endfunction

   always_comb begin
      w_grant = '0;
      for (int j = 0; j < M_DATA_COUNT; j++) begin
         w_owned[j] = '0;
         if (r_state[j] == StLocked) w_owned[j][r_owner[j]] = 1'b1;
         w_grant = w_grant | w_owned[j];
      end
      for (int i = 0; i < S_DATA_COUNT; i++) begin
         w_dest_err[i] = s_valid_i[i] && (int'(s_dest_i[i]) >= M_DATA_COUNT);
      end
      for (int j = 0; j < M_DATA_COUNT; j++) begin
         for (int i = 0; i < S_DATA_COUNT; i++) begin
            w_req_raw[j][i] = s_valid_i[i] && (int'(s_dest_i[i]) == j);
         end
         // A slave already owning a different master must not compete here.
         w_req[j]      = w_req_raw[j] & ~(w_grant & ~w_owned[j]);
         w_conflict[j] = ($countones(w_req_raw[j]) >= 2);
         w_end[j]      = (r_state[j] == StLocked) && s_valid_i[r_owner[j]] && m_ready_i[j] &&
                         ((LOCK_ON_LAST == 0) || s_last_i[r_owner[j]]);
         w_start[j]    = (r_state[j] == StLocked) ? wrap_inc(r_owner[j]) : r_ptr[j];
         {w_any[j], w_pick[j]} = rr_pick(w_req[j], w_start[j]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int j = 0; j < M_DATA_COUNT; j++) begin
            r_state[j] <= StIdle;
            r_owner[j] <= '0;
            r_ptr[j]   <= '0;
         end
         r_conflict <= '0;
         r_dest_err <= '0;
      end else begin
         for (int j = 0; j < M_DATA_COUNT; j++) begin
            case (r_state[j])
               StIdle: begin
                  if (w_any[j]) begin
                     r_state[j] <= StLocked;
                     r_owner[j] <= w_pick[j];
                  end
               end
               StLocked: begin
                  if (w_end[j]) begin
                     r_ptr[j] <= w_start[j];
                     if (w_any[j]) r_owner[j] <= w_pick[j];
                     else          r_state[j] <= StIdle;
                  end
               end
               default: r_state[j] <= StIdle;
            endcase
         end
         r_conflict <= w_conflict;
         r_dest_err <= w_dest_err;
      end
   end

   always_comb begin
      for (int j = 0; j < M_DATA_COUNT; j++) begin
         m_active_o[j] = (r_state[j] == StLocked);
         m_sel_o[j]    = (r_state[j] == StLocked) ? r_owner[j] : '0;
      end
   end

   assign s_grant_o    = w_grant;
   assign conflict_o   = r_conflict;
   assign s_dest_err_o = r_dest_err;

endmodule

// File: tb/tb_stream_xbar_arbiter.sv
// Bench for stream_xbar_arbiter: a lock-on-last and a per-beat instance share the same stimulus,
// each compared every cycle against a per-master round-robin model.
module tb_stream_xbar_arbiter;

   localparam int S = 2;
   localparam int M = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [S-1:0] s_valid;
   logic [1:0]   s_dest [S];
   logic [S-1:0] s_last;
   logic [M-1:0] m_ready;

   logic [M-1:0] a_active, b_active;
   logic [0:0]   a_sel [M];
   logic [0:0]   b_sel [M];
   logic [S-1:0] a_grant, b_grant;
   logic [M-1:0] a_conf, b_conf;
   logic [S-1:0] a_err, b_err;

   int n_cmp = 0;
   int n_mis = 0;

   // Model state, index 0 = lock-on-last instance, 1 = per-beat instance.
   int           md_act [2][M];
   int           md_own [2][M];
   int           md_ptr [2][M];
   logic [M-1:0] md_conf [2];
   logic [S-1:0] md_err  [2];

   always #5 clk = ~clk;

   stream_xbar_arbiter #(.S_DATA_COUNT(S), .M_DATA_COUNT(M), .LOCK_ON_LAST(1)) u_dut_lock (
      .clk(clk), .rst_n(rst_n), .s_valid_i(s_valid), .s_dest_i(s_dest), .s_last_i(s_last),
      .m_ready_i(m_ready), .m_active_o(a_active), .m_sel_o(a_sel), .s_grant_o(a_grant),
      .conflict_o(a_conf), .s_dest_err_o(a_err)
   );

   stream_xbar_arbiter #(.S_DATA_COUNT(S), .M_DATA_COUNT(M), .LOCK_ON_LAST(0)) u_dut_beat (
      .clk(clk), .rst_n(rst_n), .s_valid_i(s_valid), .s_dest_i(s_dest), .s_last_i(s_last),
      .m_ready_i(m_ready), .m_active_o(b_active), .m_sel_o(b_sel), .s_grant_o(b_grant),
      .conflict_o(b_conf), .s_dest_err_o(b_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input int d);
      int own_of [S];
      int req    [M][S];
      int nact, nown, nptr, cnt, st, p, idx, k;
      if (!rst_n) begin
         for (int j = 0; j < M; j++) begin
            md_act[d][j] = 0;
            md_own[d][j] = 0;
            md_ptr[d][j] = 0;
         end
         md_conf[d] = '0;
         md_err[d]  = '0;
         return;
      end
      for (int i = 0; i < S; i++) own_of[i] = -1;
      for (int j = 0; j < M; j++) if (md_act[d][j] != 0) own_of[md_own[d][j]] = j;
      for (int j = 0; j < M; j++) begin
         cnt = 0;
         for (int i = 0; i < S; i++) begin
            k = (s_valid[i] && int'(s_dest[i]) == j) ? 1 : 0;
            cnt += k;
            req[j][i] = (k == 1 && (own_of[i] < 0 || own_of[i] == j)) ? 1 : 0;
         end
         md_conf[d][j] = (cnt >= 2);
      end
      for (int i = 0; i < S; i++) md_err[d][i] = s_valid[i] && (int'(s_dest[i]) >= M);
      for (int j = 0; j < M; j++) begin
         nact = md_act[d][j];
         nown = md_own[d][j];
         nptr = md_ptr[d][j];
         st   = -1;
         if (md_act[d][j] == 0) begin
            st = md_ptr[d][j];
         end else begin
            k = md_own[d][j];
            if (s_valid[k] && m_ready[j] && (d == 1 || s_last[k])) begin
               nptr = (k + 1) % S;
               st   = nptr;
            end
         end
         if (st >= 0) begin
            p = -1;
            for (int off = 0; off < S; off++) begin
               idx = (st + off) % S;
               if (req[j][idx] != 0 && p < 0) p = idx;
            end
            if (p >= 0) begin
               nact = 1;
               nown = p;
            end else begin
               nact = 0;
            end
         end
         md_act[d][j] = nact;
         md_own[d][j] = nown;
         md_ptr[d][j] = nptr;
      end
   endtask

   task automatic check_dut(input int d, input logic [M-1:0] act, input logic [0:0] sel0,
                            input logic [0:0] sel1, input logic [0:0] sel2,
                            input logic [S-1:0] grant, input logic [M-1:0] conf,
                            input logic [S-1:0] err);
      logic [M-1:0] e_act;
      logic [S-1:0] e_grant;
      int           e_sel [M];
      string        nm;
      nm      = (d == 0) ? "lock" : "beat";
      e_grant = '0;
      for (int j = 0; j < M; j++) begin
         e_act[j] = (md_act[d][j] != 0);
         e_sel[j] = e_act[j] ? md_own[d][j] : 0;
         if (e_act[j]) e_grant[md_own[d][j]] = 1'b1;
      end
      chk({nm, ".active"}, 32'(act), 32'(e_act));
      chk({nm, ".sel0"}, 32'(sel0), 32'(e_sel[0]));
      chk({nm, ".sel1"}, 32'(sel1), 32'(e_sel[1]));
      chk({nm, ".sel2"}, 32'(sel2), 32'(e_sel[2]));
      chk({nm, ".grant"}, 32'(grant), 32'(e_grant));
      chk({nm, ".conflict"}, 32'(conf), 32'(md_conf[d]));
      chk({nm, ".dest_err"}, 32'(err), 32'(md_err[d]));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_dut(0, a_active, a_sel[0], a_sel[1], a_sel[2], a_grant, a_conf, a_err);
      check_dut(1, b_active, b_sel[0], b_sel[1], b_sel[2], b_grant, b_conf, b_err);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      s_valid   = 2'b11;
      s_dest[0] = 2'd0;
      s_dest[1] = 2'd0;
      s_last    = 2'b00;
      m_ready   = 3'b111;

      // Reset held with traffic present.
      cycle();
      cycle();
      chk("rst.active", 32'(a_active), 32'd0);
      chk("rst.grant", 32'(a_grant), 32'd0);
      chk("rst.conflict", 32'(a_conf), 32'd0);
      rst_n     = 1'b1;
      s_dest[0] = 2'd1;
      s_dest[1] = 2'd0;
      cycle();
      chk("rel.active", 32'(a_active), 32'b011);
      chk("rel.sel0", 32'(a_sel[0]), 32'd1);
      chk("rel.sel1", 32'(a_sel[1]), 32'd0);
      chk("rel.grant", 32'(a_grant), 32'b11);
      chk("rel.conflict", 32'(a_conf), 32'd0);

      // Contention on master 1 with 3-beat packets.
      do_reset();
      s_dest[0] = 2'd1;
      s_dest[1] = 2'd1;
      for (int k = 1; k <= 7; k++) begin
         s_last = {k == 7, k == 4};
         cycle();
         if (k == 1) begin
            chk("cont.first_sel", 32'(a_sel[1]), 32'd0);
            chk("cont.conflict", 32'(a_conf), 32'b010);
         end
         if (k == 4) begin
            chk("cont.handover_sel", 32'(a_sel[1]), 32'd1);
            chk("cont.no_bubble", 32'(a_active[1]), 32'd1);
         end
         if (k == 7) chk("cont.regain_sel", 32'(a_sel[1]), 32'd0);
      end

      // Backpressure on master 1 while the owner offers its last beat.
      s_last  = 2'b01;
      m_ready = 3'b101;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("bp.hold_sel", 32'(a_sel[1]), 32'd0);
         chk("bp.hold_active", 32'(a_active[1]), 32'd1);
      end
      m_ready = 3'b111;
      cycle();
      chk("bp.handover_sel", 32'(a_sel[1]), 32'd1);

      // Out-of-range destination.
      do_reset();
      s_valid   = 2'b01;
      s_dest[0] = 2'd3;
      s_dest[1] = 2'd0;
      s_last    = 2'b00;
      cycle();
      chk("derr.flag", 32'(a_err), 32'b01);
      chk("derr.active", 32'(a_active), 32'd0);
      chk("derr.grant", 32'(a_grant), 32'd0);

      // Per-beat instance alternates owners every cycle.
      do_reset();
      s_valid   = 2'b11;
      s_dest[0] = 2'd2;
      s_dest[1] = 2'd2;
      for (int k = 1; k <= 4; k++) begin
         cycle();
         chk($sformatf("beat.alt%0d", k), 32'(b_sel[2]), 32'((k - 1) % 2));
         chk($sformatf("beat.act%0d", k), 32'(b_active[2]), 32'd1);
      end

      // Reset while slave 1 owns master 0 with the pointer at 1.
      do_reset();
      s_dest[0] = 2'd0;
      s_dest[1] = 2'd0;
      s_last    = 2'b01;
      cycle();
      cycle();
      chk("mrst.pre_sel", 32'(a_sel[0]), 32'd1);
      rst_n = 1'b0;
      cycle();
      chk("mrst.active", 32'(a_active), 32'd0);
      chk("mrst.beat_active", 32'(b_active), 32'd0);
      rst_n = 1'b1;
      cycle();
      chk("mrst.first_sel", 32'(a_sel[0]), 32'd0);
      chk("mrst.first_active", 32'(a_active), 32'b001);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 800; n++) begin
         rst_n   = ($urandom_range(0, 63) != 0);
         s_valid = 2'($urandom);
         for (int i = 0; i < S; i++) begin
            s_dest[i] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            s_last[i] = ($urandom_range(0, 2) == 0);
         end
         for (int j = 0; j < M; j++) m_ready[j] = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/stream_xbar_arbiter.md
Name: stream_xbar_arbiter

Overview:
Per-master-port round-robin arbiter for the stream crossbar, the sequential successor to the combinational conflict detector. For every master port it collects requests from all slave ports whose destination selects it, grants one owner, and holds that grant until the packet ends. It also reports per-master contention and out-of-range destinations. Its outputs drive the crossbar data muxes and the slave-side ready gating.

Parameters:
S_DATA_COUNT, 2, number of slave (input) stream ports, >=2
M_DATA_COUNT, 3, number of master (output) stream ports, >=1
LOCK_ON_LAST, 1, 1: grant held until a last-beat handshake; 0: every beat treated as last (per-beat arbitration)
T_DEST_WIDTH, $clog2(M_DATA_COUNT) (localparam, min 1), destination field width
S_ID_WIDTH, $clog2(S_DATA_COUNT) (localparam, min 1), owner index width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
s_valid_i  input  [S_DATA_COUNT-1:0]  slave port has a valid beat
s_dest_i  input  [T_DEST_WIDTH-1:0] x S_DATA_COUNT  unpacked array, destination of each slave beat
s_last_i  input  [S_DATA_COUNT-1:0]  beat is last of packet
m_ready_i  input  [M_DATA_COUNT-1:0]  downstream ready per master port
m_active_o  output  [M_DATA_COUNT-1:0]  master port has an owner (LOCKED)
m_sel_o  output  [S_ID_WIDTH-1:0] x M_DATA_COUNT  unpacked array, owner slave index per master
s_grant_o  output  [S_DATA_COUNT-1:0]  slave i owns some master port
conflict_o  output  [M_DATA_COUNT-1:0]  registered: >=2 requesters for master j in previous cycle
s_dest_err_o  output  [S_DATA_COUNT-1:0]  registered: slave i valid with s_dest_i >= M_DATA_COUNT in previous cycle

Behaviour:
- Request: req[j][i] = s_valid_i[i] && s_dest_i[i]==j && slave i not owner of another master. A destination >= M_DATA_COUNT never requests.
- Per master j: state IDLE/LOCKED, owner[j], pointer ptr[j] in 0..S_DATA_COUNT-1.
- RR pick: the first i with req[j][i] scanning ptr[j], ptr[j]+1, ... modulo S_DATA_COUNT.
- IDLE with any req -> LOCKED next cycle, owner = pick. Grant latency is 1 cycle from request. No req -> stay IDLE.
- LOCKED, owner k. A beat transfers when s_valid_i[k] && m_ready_i[j].
- While locked, s_dest_i[k] and other requests are ignored. The lock is held even if the owner changes destination mid-packet.
- Transfer with end (s_last_i[k], or any transfer when LOCK_ON_LAST=0):
  - ptr[j] <= (k+1) mod S.
  - Same-cycle re-arbitration from pointer k+1 using current requests. If a requester exists -> LOCKED with the new owner, with no bubble. Otherwise -> IDLE.
  - The owner may win again only if no other slave requests.
- Transfer without end, or no transfer: hold state.
- A slave owns at most one master at a time, enforced by request masking.
- Simultaneous IDLE pick on two masters cannot select the same slave, because a slave has a single destination.
- Outputs:
  - m_active_o[j] = (state==LOCKED).
  - m_sel_o[j] = owner when active, 0 when IDLE.
  - s_grant_o[i] = OR over j of (active && owner==i).
- conflict_o[j] <= popcount of raw requests for master j >= 2. Raw means valid && dest match, ignoring lock masking. Registered every cycle.
- s_dest_err_o[i] <= s_valid_i[i] && s_dest_i[i] >= M_DATA_COUNT.
- Reset (rst_n low at rising edge) forces:
  - All masters IDLE, ptr=0, owner=0.
  - All outputs 0.
  - Reset mid-packet drops the lock immediately; there is no drain.
- Inputs are sampled only at rising edges. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: rst_n=0 for 2 cycles with s_valid_i=2'b11 -> all outputs 0. After release, with dest {1,0}: m_active_o=3'b011, m_sel_o[0]=1, m_sel_o[1]=0, s_grant_o=2'b11, conflict_o=0.
- Contention: both slaves dest=1, valid, m_ready_i=all 1, 3-beat packets (last on beat 3). Expected sequence:
  - Slave 0 owns master 1 first, conflict_o=3'b010.
  - After slave 0's last beat, m_sel_o[1]=1 on the next cycle with no IDLE cycle.
  - After slave 1's last beat, slave 0 regains.
- Backpressure: owner mid-packet, m_ready_i[1]=0 for 4 cycles while slave 1 requests -> owner unchanged, m_active_o[1] held. With s_valid and last asserted, the handover occurs on the cycle after m_ready_i returns to 1.
- Invalid dest: s_dest_i[0]=3 with M=3, valid -> s_dest_err_o=2'b01 one cycle later. No master active for slave 0.
- Per-beat mode LOCK_ON_LAST=0: both slaves dest=2, s_last_i=0, ready=1 -> m_sel_o[2] alternates 0,1,0,1 every cycle.
- Mid-packet reset: owner locked on master 0, rst_n=0 for 1 cycle -> next cycle all IDLE, ptr reset. With requests present, slave 0 wins first after release.
